// File: rtl/scan_array_ctrl.sv
// Row/column select sequencer: background sweep (row fast, column slow) sharing the array
// with a host port. Optional `STARVE_GUARD_EN bounds consecutive host grants during a sweep.
module scan_array_ctrl #(
    parameter int unsigned ROWS         = 3,
    parameter int unsigned COLS         = 3,
    parameter bit          CONTINUOUS   = 1'b0,
    parameter int unsigned MAX_HOST_RUN = 4,
    localparam int unsigned RW = (ROWS > 2) ? $clog2(ROWS) : 1,
    localparam int unsigned CW = (COLS > 2) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scan_start,
    input  logic            scan_abort,
    input  logic            host_req,
    input  logic [RW-1:0]   host_row,
    input  logic [CW-1:0]   host_col,
    input  logic            host_we,
    output logic            host_gnt,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_sel,
    output logic            cell_en,
    output logic            cell_we,
    output logic            active_src,
    output logic            host_err,
    output logic            scan_done
);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [ROWS-1:0] row_sel_q, row_sel_d;
    logic [COLS-1:0] col_sel_q, col_sel_d;
    logic            cell_en_q, cell_en_d;
    logic            cell_we_q, cell_we_d;
    logic            active_src_q, active_src_d;
    logic            host_err_q, host_err_d;
    logic            scan_done_q, scan_done_d;

    logic host_acc;
    logic host_ok;
    logic last_row;
    logic last_cell;

`ifdef STARVE_GUARD_EN
    localparam int unsigned HW = $clog2(MAX_HOST_RUN + 1);
    logic [HW-1:0] run_q, run_d;

    // After MAX_HOST_RUN back-to-back host grants in a sweep, one edge goes to the scan.
    assign host_gnt = host_req && !rst && !(state_q == StSweep && run_q == HW'(MAX_HOST_RUN));
    assign run_d    = (host_acc && state_q == StSweep) ? run_q + HW'(1) : '0;
`else
    assign host_gnt = host_req && !rst;
`endif

    assign host_acc  = host_req && host_gnt;
    assign host_ok   = (32'(host_row) < ROWS) && (32'(host_col) < COLS);
    assign last_row  = (row_q == RW'(ROWS - 1));
    assign last_cell = last_row && (col_q == CW'(COLS - 1));

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        row_sel_d    = '0;
        col_sel_d    = '0;
        cell_en_d    = 1'b0;
        cell_we_d    = 1'b0;
        active_src_d = 1'b0;
        host_err_d   = 1'b0;
        scan_done_d  = 1'b0;

        if (host_acc) begin
            active_src_d = 1'b1;
            if (host_ok) begin
                cell_en_d = 1'b1;
                cell_we_d = host_we;
                row_sel_d = ROWS'(1) << host_row;
                col_sel_d = COLS'(1) << host_col;
            end else begin
                host_err_d = 1'b1;
            end
        end else if (state_q == StSweep && !scan_abort) begin
            cell_en_d   = 1'b1;
            row_sel_d   = ROWS'(1) << row_q;
            col_sel_d   = COLS'(1) << col_q;
            scan_done_d = last_cell;
            if (last_row) begin
                row_d = '0;
                col_d = last_cell ? '0 : col_q + CW'(1);
            end else begin
                row_d = row_q + RW'(1);
            end
            if (last_cell && !CONTINUOUS) begin
                state_d = StIdle;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (scan_start && !scan_abort) begin
                    state_d = StSweep;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StSweep: begin
                if (scan_abort) begin
                    state_d = StIdle;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            row_q        <= '0;
            col_q        <= '0;
            row_sel_q    <= '0;
            col_sel_q    <= '0;
            cell_en_q    <= 1'b0;
            cell_we_q    <= 1'b0;
            active_src_q <= 1'b0;
            host_err_q   <= 1'b0;
            scan_done_q  <= 1'b0;
`ifdef STARVE_GUARD_EN
            run_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            row_sel_q    <= row_sel_d;
            col_sel_q    <= col_sel_d;
            cell_en_q    <= cell_en_d;
            cell_we_q    <= cell_we_d;
            active_src_q <= active_src_d;
            host_err_q   <= host_err_d;
            scan_done_q  <= scan_done_d;
`ifdef STARVE_GUARD_EN
            run_q        <= run_d;
`endif
        end
    end

    assign row_sel    = row_sel_q;
    assign col_sel    = col_sel_q;
    assign cell_en    = cell_en_q;
    assign cell_we    = cell_we_q;
    assign active_src = active_src_q;
    assign host_err   = host_err_q;
    assign scan_done  = scan_done_q;

endmodule
